// File: rtl/matvec_stream.sv
// Streaming fixed-point y = W*x: x is buffered once, W streams row-major,
// and each y[i] is emitted on a valid/ready stream as soon as its row completes.
module matvec_stream #(
  parameter int N    = 128,
  parameter int D    = 32,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 2*DW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] x_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic signed [DW-1:0] w_data,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic signed [DW-1:0] y_data,
  output logic                 y_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(D - 1);
  localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD_X, MAC, OUT} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   xbuf [N];

  logic                   x_hs, w_hs, y_hs, col_end, row_end;
  logic signed [2*DW-1:0] w_ext, x_ext, prod;
  logic signed [ACCW-1:0] prod_ext, sum;

  // Floor (arithmetic shift) to the output scale, then clamp to DW bits.
  function automatic logic signed [DW-1:0] shift_sat(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] s;
    s = v >>> FRAC;
    if (s > Y_MAX)
      return Y_MAX[DW-1:0];
    else if (s < Y_MIN)
      return Y_MIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  assign x_hs    = x_valid & x_ready;
  assign w_hs    = w_valid & w_ready;
  assign y_hs    = y_valid & y_ready;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  assign w_ext    = (2*DW)'(w_data);
  assign x_ext    = (2*DW)'(xbuf[col]);
  assign prod     = w_ext * x_ext;
  assign prod_ext = ACCW'(prod);
  // First beat of a row starts a fresh sum instead of adding to the stale one.
  assign sum      = (col == '0) ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    w_ready   = 1'b0;
    y_valid   = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nxt = LOAD_X;
      end
      LOAD_X: begin
        x_ready = 1'b1;
        if (x_hs && col_end)
          state_nxt = MAC;
      end
      MAC: begin
        w_ready = 1'b1;
        if (w_hs && col_end)
          state_nxt = OUT;
      end
      OUT: begin
        y_valid = 1'b1;
        if (y_hs)
          state_nxt = row_end ? IDLE : MAC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      col    <= '0;
      row    <= '0;
      acc    <= '0;
      y_data <= '0;
      y_last <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            col <= '0;
            row <= '0;
          end
        end
        LOAD_X: begin
          if (x_hs)
            col <= col_end ? '0 : col + 1'b1;
        end
        MAC: begin
          if (w_hs) begin
            acc <= sum;
            if (col_end) begin
              col    <= '0;
              y_data <= shift_sat(sum);
              y_last <= row_end;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        OUT: begin
          if (y_hs) begin
            if (row_end)
              done <= 1'b1;
            else
              row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // x buffer is deliberately left out of reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (x_hs)
      xbuf[col] <= x_data;
  end

endmodule

// File: tb/tb_matvec_stream.sv
// Scoreboard bench for matvec_stream: a small N=4/D=2 instance for directed cases
// and an N=128/D=32 instance for random data against a bit-accurate model.
module tb_matvec_stream;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start   [2];
  logic          x_valid [2];
  logic          x_ready [2];
  logic [DW-1:0] x_data  [2];
  logic          w_valid [2];
  logic          w_ready [2];
  logic [DW-1:0] w_data  [2];
  logic          y_valid [2];
  logic          y_ready [2];
  logic [DW-1:0] y_data  [2];
  logic          y_last  [2];
  logic          busy    [2];
  logic          done    [2];

  matvec_stream #(.N(4), .D(2), .DW(16), .FRAC(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .x_valid(x_valid[0]), .x_ready(x_ready[0]), .x_data(x_data[0]),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]),
    .y_valid(y_valid[0]), .y_ready(y_ready[0]), .y_data(y_data[0]),
    .y_last(y_last[0]), .busy(busy[0]), .done(done[0])
  );

  matvec_stream #(.N(128), .D(32), .DW(16), .FRAC(8)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .x_valid(x_valid[1]), .x_ready(x_ready[1]), .x_data(x_data[1]),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]),
    .y_valid(y_valid[1]), .y_ready(y_ready[1]), .y_data(y_data[1]),
    .y_last(y_last[1]), .busy(busy[1]), .done(done[1])
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          act_k = 0;
  int          ycnt  = 0;
  int          done_chk = 0;
  bit          wr_chk = 0;
  bit          stall_prev = 0;
  bit          tout = 0;
  logic [17:0] prev_y;
  logic [16:0] e;
  logic [16:0] exp_q [$];

  logic [15:0] xv [128];
  logic [15:0] wv [4096];
  logic [15:0] ye [32];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] ref_row(input int i, input int n);
    longint s = 0;
    longint q;
    for (int j = 0; j < n; j++)
      s += longint'($signed(wv[i*n+j])) * longint'($signed(xv[j]));
    q = s >>> 8;
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  task automatic chk_reset(input int k);
    chk("rst_x_ready", x_ready[k], 0);
    chk("rst_w_ready", w_ready[k], 0);
    chk("rst_y_valid", y_valid[k], 0);
    chk("rst_y_data",  y_data[k],  0);
    chk("rst_y_last",  y_last[k],  0);
    chk("rst_busy",    busy[k],    0);
    chk("rst_done",    done[k],    0);
  endtask

  // One x or W beat, optional random idle cycles first; returns just after the accepting edge.
  task automatic send(input int k, input bit isw, input logic [15:0] d, input int gap);
    bit hs;
    int c;
    if (tout) return;
    while ($urandom_range(0, 99) < gap) begin
      @(posedge clk); #1;
    end
    if (isw) begin w_data[k] = d; w_valid[k] = 1'b1; end
    else     begin x_data[k] = d; x_valid[k] = 1'b1; end
    hs = 1'b0;
    c  = 0;
    while (!hs && !tout) begin
      @(negedge clk);
      hs = isw ? w_ready[k] : x_ready[k];
      @(posedge clk); #1;
      c++;
      if (!hs && c > 5000) begin
        tout = 1'b1;
        chk(isw ? "w_timeout" : "x_timeout", 0, 1);
      end
    end
    w_valid[k] = 1'b0;
    x_valid[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input int gap, input int yr_pct, input bit bp5, input bit pulse);
    int n, d;
    bit bpd;
    n   = (k == 1) ? 128 : 4;
    d   = (k == 1) ? 32 : 2;
    bpd = 1'b0;
    act_k = k;
    ycnt  = 0;
    tout  = 1'b0;
    for (int i = 0; i < d; i++)
      exp_q.push_back({(i == d-1), ye[i]});
    @(posedge clk); #1;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk("busy_start", busy[k], 1);
    chk("x_ready_start", x_ready[k], 1);
    fork
      begin
        for (int j = 0; j < n; j++)
          send(k, 1'b0, xv[j], gap);
        for (int j = 0; j < n*d; j++) begin
          send(k, 1'b1, wv[j], gap);
          if ((j % n) == n-1 && !tout)
            chk("y_valid_latency", y_valid[k], 1);
        end
      end
      begin
        int c = 0;
        while (ycnt < d && !tout) begin
          @(posedge clk); #1;
          c++;
          if (c > 12000) begin
            tout = 1'b1;
            chk("y_timeout", ycnt, d);
          end else if (bp5 && !bpd && y_valid[k]) begin
            y_ready[k] = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            bpd = 1'b1;
            y_ready[k] = 1'b1;
          end else begin
            y_ready[k] = ($urandom_range(0, 99) >= yr_pct);
          end
        end
        y_ready[k] = 1'b1;
      end
      begin
        if (pulse) begin
          while (ycnt < d && !tout) begin
            @(posedge clk); #1;
            start[k] = busy[k] && !(y_valid[k] && y_last[k]) && ($urandom_range(0, 3) == 0);
          end
        end
        start[k] = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("y_count", ycnt, d);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_basic();
    for (int j = 0; j < 4; j++) begin
      xv[j]   = 16'h0100;
      wv[j]   = 16'h0100 * 16'(j + 1);
      wv[4+j] = 16'hFF00;
    end
    ye[0] = 16'h0A00;
    ye[1] = 16'hFC00;
  endtask

  // Output-side scoreboard and handshake-rule checks, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (done_chk == 1) begin
          chk("done_pulse", done[act_k], 1);
          chk("busy_after_last", busy[act_k], 0);
          done_chk = 2;
        end else if (done_chk == 2) begin
          chk("done_width", done[act_k], 0);
          done_chk = 0;
        end
        if (wr_chk) begin
          chk("w_ready_resume", w_ready[act_k], 1);
          wr_chk = 1'b0;
        end
        if (stall_prev)
          chk("y_hold", {y_valid[act_k], y_last[act_k], y_data[act_k]}, prev_y);
        if (y_valid[act_k])
          chk("w_ready_in_out", w_ready[act_k], 0);
        stall_prev = y_valid[act_k] && !y_ready[act_k];
        prev_y     = {y_valid[act_k], y_last[act_k], y_data[act_k]};
        if (y_valid[act_k] && y_ready[act_k]) begin
          if (exp_q.size() == 0) begin
            chk("y_extra", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("y_data", y_data[act_k], e[15:0]);
            chk("y_last", y_last[act_k], e[16]);
            if (e[16]) done_chk = 1;
            else       wr_chk = 1'b1;
          end
          ycnt++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; x_valid[k] = 1'b0; w_valid[k] = 1'b0;
      x_data[k] = '0;  w_data[k] = '0;   y_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Basic
    load_basic();
    run_op(0, 0, 0, 1'b0, 1'b0);

    // Saturation both directions
    for (int j = 0; j < 4; j++) begin
      xv[j] = 16'h7F00; wv[j] = 16'h7F00; wv[4+j] = 16'h8100;
    end
    ye[0] = 16'h7FFF; ye[1] = 16'h8000;
    run_op(0, 0, 0, 1'b0, 1'b0);

    // Floor rounding
    for (int j = 0; j < 4; j++) begin
      xv[j] = 16'h0001; wv[j] = 16'h0080; wv[4+j] = 16'hFFFF;
    end
    ye[0] = 16'h0002; ye[1] = 16'hFFFF;
    run_op(0, 0, 0, 1'b0, 1'b0);

    // Input gaps and a 5-cycle output stall
    load_basic();
    run_op(0, 30, 0, 1'b1, 1'b0);

    // Reset two beats into row 0, then a clean rerun
    load_basic();
    act_k = 0;
    tout  = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int j = 0; j < 4; j++) send(0, 1'b0, xv[j], 0);
    for (int j = 0; j < 2; j++) send(0, 1'b1, wv[j], 0);
    chk("busy_before_abort", busy[0], 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    run_op(0, 0, 0, 1'b0, 1'b0);

    // Full-size random run with stray start pulses and random backpressure
    for (int j = 0; j < 128; j++) begin
      t = $urandom_range(0, 2047) - 1024;
      xv[j] = t[15:0];
    end
    for (int j = 0; j < 4096; j++) begin
      t = $urandom_range(0, 2047) - 1024;
      wv[j] = t[15:0];
    end
    for (int i = 0; i < 32; i++)
      ye[i] = ref_row(i, 128);
    run_op(1, 20, 30, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matvec_stream.md
# matvec_stream

Streaming fixed-point matrix-vector multiply, y = W·x, for the transformer datapath. It sits directly downstream of the RMS-norm stage. The normalized activation vector x (N elements) is loaded once into an internal buffer. W is then streamed row-major, one element per beat, and each of the D output elements is emitted on a valid/ready stream as soon as its row completes. All data is signed fixed point with FRAC fractional bits.

## Interface
- N, default 128: input vector length (columns of W); ≥2.
- D, default 32: output vector length (rows of W); ≥1.
- DW, default 16: data width of x, W and y, two's complement.
- FRAC, default 8: fractional bits of every operand and result (Q(DW-FRAC).FRAC).
- ACCW, default 2*DW+$clog2(N): accumulator width; sums never overflow.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset rst_n, asynchronous, active-high (rst_n=1 resets).
- start  in  1  begin an operation; sampled only in IDLE.
- x_valid  in  1  x beat valid.
- x_ready  out  1  block accepts x beat.
- x_data  in  DW  element x[j], j ascending.
- w_valid  in  1  W beat valid.
- w_ready  out  1  block accepts W beat.
- w_data  in  DW  element W[i][j], row-major.
- y_valid  out  1  y_data valid.
- y_ready  in  1  consumer accepts y beat.
- y_data  out  DW  element y[i].
- y_last  out  1  high with y_valid on y[D-1].
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse after the final y handshake.

## Operation
- States: IDLE, LOAD_X, MAC, OUT.
- IDLE: when start=1, go to LOAD_X and clear col=0, row=0. start in any other state is ignored.
- LOAD_X: x_ready=1. Each x handshake (x_valid&x_ready) writes xbuf[col] and increments col. On the handshake with col=N-1, col←0 and go to MAC.
- MAC: w_ready=1.
  - The first beat of a row loads acc = W·xbuf[col]; each later beat adds W·xbuf[col] to acc.
  - Each product is the full 2·DW-bit signed product, sign-extended to ACCW.
  - On the handshake with col=N-1: y_data ← sat(floor((acc+product) >>> FRAC)); y_last ← (row==D-1); col←0; go to OUT.
- Rounding and saturation: arithmetic right shift, i.e. truncation toward −∞. Saturate to [−2^(DW−1), 2^(DW−1)−1].
- OUT: y_valid=1 and w_ready=0. y_data and y_last hold until y_ready=1. On the handshake:
  - if row==D-1: go to IDLE and pulse done;
  - otherwise row++ and return to MAC.
- The xbuf contents persist but are always overwritten by the next LOAD_X. Reuse of x without reload is not supported.

## Timing
- Reset values: x_ready=0, w_ready=0, y_valid=0, y_data=0, y_last=0, busy=0, done=0. State=IDLE, col=row=0, acc=0. xbuf is not cleared.
- Reset asserted in any state aborts at once and drops all handshakes. No partial y is emitted afterward.
- start sampled at edge t: busy=1 and x_ready=1 from t.
- Throughput is one beat per cycle on every stream. Gaps in x_valid or w_valid stall without corrupting col or acc.
- Final W beat of a row accepted at edge k: y_valid=1 from k (latency 0 cycles after the last beat).
- y handshake at edge m:
  - not the last row: w_ready=1 from m;
  - last row: state=IDLE, busy=0, done=1 for exactly the cycle after m.
- Minimum operation length is N + D·(N+1) cycles plus the start cycle.
- w_valid during LOAD_X, OUT or IDLE is not accepted (w_ready=0). x_valid outside LOAD_X is not accepted.

## Test plan
Scenarios 1–5 use N=4, D=2, DW=16, FRAC=8.
1. Basic. x = 4×0x0100; W row0 = 0x0100, 0x0200, 0x0300, 0x0400; row1 = 4×0xFF00. Required: y0 = 0x0A00 with y_last=0; y1 = 0xFC00 with y_last=1; done pulses one cycle after the y1 handshake.
2. Saturation.
   - x = 4×0x7F00, W = 4×0x7F00 → y = 0x7FFF.
   - Same x, W = 4×0x8100 → y = 0x8000.
3. Rounding.
   - x = 4×0x0001, W = 4×0x0080 → y = 0x0002.
   - x = 4×0x0001, W = 4×0xFFFF → y = 0xFFFF (floor of −4/256).
4. Backpressure and gaps. Random w_valid gaps, plus y_ready low for 5 cycles. Required: y_data and y_valid stable; w_ready=0; no W beat consumed while OUT; results match scenario 1.
5. Reset mid-MAC. Set rst_n=1 after 2 W beats of row0. Required: all outputs at reset values next cycle. A new start with scenario 1 data gives y0=0x0A00 and y1=0xFC00.
6. start pulsed during LOAD_X, MAC and OUT. Required: ignored, with no restart and no change to col or row. With N=128 and D=32 and random data, results match a bit-accurate reference model.
